// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher, one round per clock, with an internally stored key schedule.
// Defining AES_DEC_STATUS_EN adds a sticky `err` output that flags dropped start/set_new_key.
module aes_decryption #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_new_key,
  input  logic [KEY_W-1:0] key_in,
  input  logic             start,
  input  logic             restart,
  input  logic [127:0]     cipher_text,
  output logic [127:0]     plain_text,
  output logic             done,
  output logic             busy,
`ifdef AES_DEC_STATUS_EN
  output logic             err,
`endif
  output logic             key_valid
);

  localparam logic [3:0] LastRnd = 4'(NR - 1);
  localparam logic [3:0] LastKey = 4'(NR);

  typedef enum logic [1:0] {StIdle, StKexp, StDec} state_e;

  state_e       st_q;
  logic [127:0] rk_q [NR+1];
  logic [127:0] blk_q;
  logic [3:0]   kcnt_q;
  logic [3:0]   rnd_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte n of a block sits at bits [127-8n -: 8]; byte n is row n%4, column n/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[8*n +: 8] = inv_sbox(s[8*n +: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [127:0] prev_rk, next_rk, round_key, inv_rnd, inv_rnd_mix;
  logic [31:0]  rot_w, sub_w, tmp_w, w0, w1, w2, w3;

  always_comb begin
    prev_rk = rk_q[kcnt_q - 4'd1];
    rot_w   = {prev_rk[23:0], prev_rk[31:24]};
    sub_w   = '0;
    for (int i = 0; i < 4; i++) begin
      sub_w[8*i +: 8] = sbox(rot_w[8*i +: 8]);
    end
    tmp_w   = sub_w ^ {rcon(kcnt_q), 24'h0};
    w0      = prev_rk[127:96] ^ tmp_w;
    w1      = prev_rk[95:64] ^ w0;
    w2      = prev_rk[63:32] ^ w1;
    w3      = prev_rk[31:0] ^ w2;
    next_rk = {w0, w1, w2, w3};

    round_key   = rk_q[rnd_q];
    inv_rnd     = inv_sub_bytes(inv_shift_rows(blk_q)) ^ round_key;
    inv_rnd_mix = inv_mix_columns(inv_rnd);
  end

  // Schedule and working block are not reset; key_valid gates every use of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      plain_text <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      key_valid  <= 1'b0;
      kcnt_q     <= '0;
      rnd_q      <= '0;
`ifdef AES_DEC_STATUS_EN
      err        <= 1'b0;
`endif
    end else if (restart) begin
      st_q <= StIdle;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st_q)
        StIdle: begin
          if (set_new_key) begin
            rk_q[0]   <= key_in;
            key_valid <= 1'b0;
            busy      <= 1'b1;
            kcnt_q    <= 4'd1;
            st_q      <= StKexp;
`ifdef AES_DEC_STATUS_EN
            err       <= 1'b0;
`endif
          end else if (start && key_valid) begin
            blk_q <= cipher_text ^ rk_q[NR];
            rnd_q <= LastRnd;
            busy  <= 1'b1;
            st_q  <= StDec;
          end else if (start) begin
`ifdef AES_DEC_STATUS_EN
            err <= 1'b1;
`endif
          end
        end
        StKexp: begin
          rk_q[kcnt_q] <= next_rk;
          kcnt_q       <= kcnt_q + 4'd1;
          if (kcnt_q == LastKey) begin
            key_valid <= 1'b1;
            busy      <= 1'b0;
            st_q      <= StIdle;
          end
`ifdef AES_DEC_STATUS_EN
          if (start || set_new_key) err <= 1'b1;
`endif
        end
        StDec: begin
          if (rnd_q == 4'd0) begin
            plain_text <= inv_rnd;
            done       <= 1'b1;
            busy       <= 1'b0;
            st_q       <= StIdle;
          end else begin
            blk_q <= inv_rnd_mix;
            rnd_q <= rnd_q - 4'd1;
          end
`ifdef AES_DEC_STATUS_EN
          if (start || set_new_key) err <= 1'b1;
`endif
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decryption.sv
// Bench for aes_decryption: directed control scenarios plus random keys/blocks checked
// against a table-driven FIPS-197 model (set AES_DEC_STATUS_EN to also check err).
module tb_aes_decryption;

  logic         clk = 1'b0;
  logic         reset, set_new_key, start, restart;
  logic [127:0] key_in, cipher_text, plain_text;
  logic         done, busy, key_valid;
`ifdef AES_DEC_STATUS_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] mrk     [11];
  logic [127:0] exp_pt;

  always #5 clk = ~clk;

  aes_decryption dut (
    .clk        (clk),
    .reset      (reset),
    .set_new_key(set_new_key),
    .key_in     (key_in),
    .start      (start),
    .restart    (restart),
    .cipher_text(cipher_text),
    .plain_text (plain_text),
    .done       (done),
    .busy       (busy),
`ifdef AES_DEC_STATUS_EN
    .err        (err),
`endif
    .key_valid  (key_valid)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
    return acc[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isbox_t[gb(v, i)] : sbox_t[gb(v, i)];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv ? gb(v, r + 4*((c - r + 4) % 4)) : gb(v, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - r + 4) % 4], gb(v, k + 4*c));
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  task automatic m_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ mrk[0];
    for (int r = 1; r <= 10; r++) begin
      s = m_shift(m_sub(s, 1'b0), 1'b0);
      if (r != 10) s = m_mix(s, 1'b0);
      s = s ^ mrk[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ mrk[10];
    for (int r = 9; r >= 0; r--) begin
      s = m_sub(m_shift(s, 1'b1), 1'b1) ^ mrk[r];
      if (r != 0) s = m_mix(s, 1'b1);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a key and times the expansion; optionally pokes start/set_new_key mid-expansion.
  task automatic load_key(input logic [127:0] k, input bit poke);
    int n;
    m_expand(k);
    set_new_key = 1'b1;
    key_in      = k;
    tick();
    set_new_key = 1'b0;
    key_in      = rnd128();
    check1("kexp_busy", busy, 1'b1);
    check1("kexp_key_valid_low", key_valid, 1'b0);
`ifdef AES_DEC_STATUS_EN
    check1("err_cleared_by_key", err, 1'b0);
`endif
    n = 0;
    while (!key_valid && n < 20) begin
      if (poke && n == 2) begin
        start       = 1'b1;
        cipher_text = rnd128();
      end
      if (poke && n == 4) set_new_key = 1'b1;
      tick();
      start       = 1'b0;
      set_new_key = 1'b0;
      n++;
    end
    check_int("kexp_cycles", n, 10);
    check1("kexp_done_idle", busy, 1'b0);
    check1("kexp_no_done", done, 1'b0);
`ifdef AES_DEC_STATUS_EN
    if (poke) check1("err_kexp_drop", err, 1'b1);
`endif
  endtask

  // One decrypt: poke_at pulses start at that edge, restart_at aborts at that edge (0 = none).
  task automatic run_dec(input logic [127:0] ct, input logic [127:0] exp,
                         input int poke_at, input int restart_at);
    int ndone, first;
    start       = 1'b1;
    cipher_text = ct;
    tick();
    start       = 1'b0;
    cipher_text = rnd128();
    check1("dec_busy", busy, 1'b1);
    ndone = 0;
    first = 0;
    for (int n = 1; n <= 14; n++) begin
      if (n == poke_at) begin
        start       = 1'b1;
        cipher_text = rnd128();
      end
      if (n == restart_at) restart = 1'b1;
      tick();
      start   = 1'b0;
      restart = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = n;
      end
      if (n == restart_at) begin
        check1("restart_busy", busy, 1'b0);
        check1("restart_done", done, 1'b0);
        check128("restart_pt_kept", plain_text, exp_pt);
      end
    end
    if (restart_at > 0) begin
      check_int("restart_no_done", ndone, 0);
      check1("restart_key_valid", key_valid, 1'b1);
    end else begin
      check_int("dec_done_count", ndone, 1);
      check_int("dec_latency", first, 10);
      check128("dec_plain_text", plain_text, exp);
      check1("dec_idle", busy, 1'b0);
      exp_pt = exp;
    end
  endtask

  task automatic expect_dropped_start(input string tag);
    int ndone;
    start       = 1'b1;
    cipher_text = rnd128();
    tick();
    start = 1'b0;
    check1({tag, "_busy"}, busy, 1'b0);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) ndone++;
    end
    check_int({tag, "_no_done"}, ndone, 0);
    check128({tag, "_pt"}, plain_text, exp_pt);
  endtask

  localparam logic [127:0] Key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Ct1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Pt1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Key2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Ct2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Pt2  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] k, p, c;
    reset       = 1'b1;
    set_new_key = 1'b0;
    start       = 1'b0;
    restart     = 1'b0;
    key_in      = '0;
    cipher_text = '0;
    exp_pt      = '0;
    build_tables();
    tick();
    tick();
    reset = 1'b0;
    check128("reset_pt", plain_text, 128'h0);
    check1("reset_done", done, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_key_valid", key_valid, 1'b0);

    expect_dropped_start("nokey_start");
`ifdef AES_DEC_STATUS_EN
    check1("err_nokey", err, 1'b1);
`endif

    load_key(Key1, 1'b1);
    run_dec(Ct1, Pt1, 0, 0);

    load_key(Key2, 1'b0);
    run_dec(Ct2, Pt2, 0, 0);
    run_dec(Ct2, Pt2, 0, 0);
    run_dec(Ct2, Pt2, 3, 0);
`ifdef AES_DEC_STATUS_EN
    check1("err_dec_drop", err, 1'b1);
`endif

    run_dec(rnd128(), 128'h0, 0, 5);
    run_dec(Ct2, Pt2, 0, 0);

    for (int it = 0; it < 3; it++) begin
      k = rnd128();
      load_key(k, 1'b0);
      p = rnd128();
      run_dec(m_encrypt(p), p, 0, 0);
      c = rnd128();
      run_dec(c, m_decrypt(c), 0, 0);
    end

    // Restart during key expansion leaves no usable schedule.
    set_new_key = 1'b1;
    key_in      = Key1;
    tick();
    set_new_key = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check1("kexp_restart_busy", busy, 1'b0);
    check1("kexp_restart_key_valid", key_valid, 1'b0);
    expect_dropped_start("kexp_restart_start");
    load_key(Key1, 1'b0);
    run_dec(Ct1, Pt1, 0, 0);

    // Reset in the middle of a decrypt.
    start       = 1'b1;
    cipher_text = Ct1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    exp_pt = '0;
    check128("midreset_pt", plain_text, 128'h0);
    check1("midreset_done", done, 1'b0);
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_key_valid", key_valid, 1'b0);
`ifdef AES_DEC_STATUS_EN
    check1("midreset_err", err, 1'b0);
`endif
    expect_dropped_start("midreset_start");
    load_key(Key2, 1'b0);
    run_dec(Ct2, Pt2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
